// File: rtl/lsu_axi.sv
// lsu_axi: load/store unit issuing one single-beat AXI4 read or write per accepted operation
// Ports: clk_i, rst_i (async active-high); e_* accept handshake from execute with the operation
//   fields; m_valid_o/m_ready_i/rdata_o/err_o result handshake to write-back; mst_ar/r/aw/w/b_*
//   AXI4 master channels (id, len and burst are tied off by the instantiating top).
// Option: YSYX_23060251_LSU_ALIGN_CHECK_EN makes misaligned half/word accesses complete locally
//   with err_o set and no bus traffic; without it they are issued as-is.
module lsu_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              e_valid_i,
  output logic              e_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wenMem_i,
  input  logic              renMem_i,
  input  logic [1:0]        size_i,
  input  logic              is_load_signed_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mst_ar_valid_o,
  input  logic              mst_ar_ready_i,
  output logic [ADDR_W-1:0] mst_ar_addr_o,
  output logic [2:0]        mst_ar_size_o,
  input  logic              mst_r_valid_i,
  output logic              mst_r_ready_o,
  input  logic [DATA_W-1:0] mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  output logic              mst_aw_valid_o,
  input  logic              mst_aw_ready_i,
  output logic [ADDR_W-1:0] mst_aw_addr_o,
  output logic [2:0]        mst_aw_size_o,
  output logic              mst_w_valid_o,
  input  logic              mst_w_ready_i,
  output logic [DATA_W-1:0] mst_w_data_o,
  output logic [3:0]        mst_w_strb_o,
  output logic              mst_w_last_o,
  input  logic              mst_b_valid_i,
  output logic              mst_b_ready_o,
  input  logic [1:0]        mst_b_resp_i
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] size_q;
  logic sgn_q, mis;
  logic [DATA_W-1:0] sh, ext;
  assign e_ready_o = state == IDLE;
  assign mst_ar_addr_o = addr_q;
  assign mst_aw_addr_o = addr_q;
  assign mst_ar_size_o = {1'b0, size_q};
  assign mst_aw_size_o = {1'b0, size_q};
  assign mst_w_last_o = 1'b1;
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
  assign mis = (renMem_i | wenMem_i) & (((size_i == 2'd1) & addr_i[0]) | ((size_i == 2'd2) & (addr_i[1:0] != 2'd0)));
`else
  assign mis = 1'b0;
`endif
  assign sh = mst_r_data_i >> {addr_q[1:0], 3'b000};
  assign ext = size_q == 2'd0 ? {{24{sgn_q & sh[7]}}, sh[7:0]} :
               size_q == 2'd1 ? {{16{sgn_q & sh[15]}}, sh[15:0]} : sh;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  // WR leaves once each of AW and W is either already done or handshaking now
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (e_valid_i) state_n = mis ? DONE : renMem_i ? RD_A : wenMem_i ? WR : DONE;
      RD_A: if (mst_ar_ready_i) state_n = RD_D;
      RD_D: if (mst_r_valid_i) state_n = DONE;
      WR:   if ((!mst_aw_valid_o || mst_aw_ready_i) && (!mst_w_valid_o || mst_w_ready_i)) state_n = WR_B;
      WR_B: if (mst_b_valid_i) state_n = DONE;
      DONE: if (m_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Handshake outputs are registered copies of the next state so nothing input-to-output is combinational
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mst_ar_valid_o <= 1'b0;
      mst_r_ready_o <= 1'b0;
      mst_aw_valid_o <= 1'b0;
      mst_w_valid_o <= 1'b0;
      mst_b_ready_o <= 1'b0;
      m_valid_o <= 1'b0;
      rdata_o <= '0;
      err_o <= 1'b0;
      addr_q <= '0;
      size_q <= 2'd0;
      sgn_q <= 1'b0;
      mst_w_data_o <= '0;
      mst_w_strb_o <= 4'd0;
    end else begin
      mst_ar_valid_o <= state_n == RD_A;
      mst_r_ready_o <= state_n == RD_D;
      mst_aw_valid_o <= (state_n == WR) & ((state != WR) | (mst_aw_valid_o & ~mst_aw_ready_i));
      mst_w_valid_o <= (state_n == WR) & ((state != WR) | (mst_w_valid_o & ~mst_w_ready_i));
      mst_b_ready_o <= state_n == WR_B;
      m_valid_o <= state_n == DONE;
      if (e_ready_o & e_valid_i) begin
        addr_q <= addr_i;
        size_q <= size_i;
        sgn_q <= is_load_signed_i;
        mst_w_data_o <= wdata_i << {addr_i[1:0], 3'b000};
        mst_w_strb_o <= (size_i == 2'd0 ? 4'b0001 : size_i == 2'd1 ? 4'b0011 : 4'b1111) << addr_i[1:0];
        rdata_o <= '0;
        err_o <= mis;
      end
      if ((state == RD_D) & mst_r_valid_i) begin
        rdata_o <= ext;
        err_o <= mst_r_resp_i != 2'd0;
      end
      if ((state == WR_B) & mst_b_valid_i) err_o <= mst_b_resp_i != 2'd0;
    end
endmodule

// File: tb/tb_lsu_axi.sv
// tb_lsu_axi: table vectors, reset corner cases and randomized operations against a byte-lane model
module tb_lsu_axi;
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic e_valid_i = 1'b0, e_ready_o;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic wenMem_i = 1'b0, renMem_i = 1'b0, is_load_signed_i = 1'b0;
  logic [1:0] size_i = 2'd0;
  logic m_valid_o, m_ready_i = 1'b0, err_o;
  logic [31:0] rdata_o;
  logic mst_ar_valid_o, mst_ar_ready_i = 1'b0;
  logic [31:0] mst_ar_addr_o;
  logic [2:0] mst_ar_size_o;
  logic mst_r_valid_i = 1'b0, mst_r_ready_o;
  logic [31:0] mst_r_data_i = '0;
  logic [1:0] mst_r_resp_i = 2'd0;
  logic mst_aw_valid_o, mst_aw_ready_i = 1'b0;
  logic [31:0] mst_aw_addr_o;
  logic [2:0] mst_aw_size_o;
  logic mst_w_valid_o, mst_w_ready_i = 1'b0, mst_w_last_o;
  logic [31:0] mst_w_data_o;
  logic [3:0] mst_w_strb_o;
  logic mst_b_valid_i = 1'b0, mst_b_ready_o;
  logic [1:0] mst_b_resp_i = 2'd0;

  lsu_axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .e_valid_i(e_valid_i), .e_ready_o(e_ready_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .wenMem_i(wenMem_i), .renMem_i(renMem_i),
    .size_i(size_i), .is_load_signed_i(is_load_signed_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .rdata_o(rdata_o), .err_o(err_o),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_size_o(mst_ar_size_o),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
    .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_size_o(mst_aw_size_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o), .mst_w_last_o(mst_w_last_o),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o), .mst_b_resp_i(mst_b_resp_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr, wdata, sdata;
    logic wen, ren, sgn;
    logic [1:0] size, resp;
    int ar_d, aw_d, w_d, r_d, b_d, m_d;
  } op_t;

  typedef struct {
    logic [31:0] rdata, axaddr, wdat;
    logic [3:0] strb;
    logic [2:0] axsize;
    logic err, stable;
    int lat, nar, naw, nw, nresp;
  } res_t;

  typedef struct {
    op_t o;
    logic [31:0] rd;
    logic er;
    int lat, nar, naw;
    logic [31:0] wd;
    logic [3:0] st;
  } vec_t;

  int checks = 0, passes = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  function automatic op_t mk(input logic [31:0] a, wd, sd, input logic wen, ren, sgn,
                             input logic [1:0] sz, rs, input int ard, awd, wdd, rd, bd, md);
    op_t o;
    o.addr = a; o.wdata = wd; o.sdata = sd; o.wen = wen; o.ren = ren; o.sgn = sgn;
    o.size = sz; o.resp = rs; o.ar_d = ard; o.aw_d = awd; o.w_d = wdd; o.r_d = rd;
    o.b_d = bd; o.m_d = md;
    return o;
  endfunction

  // Reference: bytes picked by lane, sign extension as subtraction of 2^(8n)
  function automatic res_t model(input op_t o);
    res_t e;
    int a, n;
    logic [31:0] v;
    e = '{default: 0};
    e.stable = 1'b1;
    a = int'(o.addr[1:0]);
    n = o.size == 2'd0 ? 1 : o.size == 2'd1 ? 2 : 4;
    e.lat = 1;
    if (!(o.ren || o.wen)) return e;
    if (ALN && (a % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.err = o.resp != 2'd0;
    e.axaddr = o.addr;
    e.axsize = {1'b0, o.size};
    e.nresp = 1;
    if (o.ren) begin
      v = '0;
      for (int i = 0; i < n; i++) if (a + i < 4) v[8*i +: 8] = o.sdata[8*(a+i) +: 8];
      if (n < 4 && o.sgn && v[8*n-1]) v = v - (32'd1 << (8*n));
      e.rdata = v;
      e.nar = 1;
      e.lat = 3 + o.ar_d + o.r_d;
    end else begin
      for (int l = 0; l < 4; l++) if (l >= a) begin
        e.wdat[8*l +: 8] = o.wdata[8*(l-a) +: 8];
        e.strb[l] = (l - a) < n;
      end
      e.naw = 1;
      e.nw = 1;
      e.lat = 3 + (o.aw_d > o.w_d ? o.aw_d : o.w_d) + o.b_d;
    end
    return e;
  endfunction

  task automatic run(input op_t o, output res_t r);
    int arw, aww, ww, rw, bw, mw;
    bit done, seen_a, seen_w, pa, paw, pw;
    r = '{default: 0};
    r.stable = 1'b1;
    r.lat = -1;
    arw = 0; aww = 0; ww = 0; rw = 0; bw = 0; mw = 0;
    done = 0; seen_a = 0; seen_w = 0; pa = 0; paw = 0; pw = 0;
    @(negedge clk_i);
    if (e_ready_o !== 1'b1) r.stable = 1'b0;
    e_valid_i = 1'b1; addr_i = o.addr; wdata_i = o.wdata; wenMem_i = o.wen;
    renMem_i = o.ren; size_i = o.size; is_load_signed_i = o.sgn;
    @(posedge clk_i);
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk_i);
      e_valid_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
      wenMem_i = 1'($urandom); renMem_i = 1'($urandom); size_i = 2'($urandom);
      is_load_signed_i = 1'($urandom);
      if (e_ready_o !== 1'b0) r.stable = 1'b0;
      if ((pa && !mst_ar_valid_o) || (paw && !mst_aw_valid_o) || (pw && !mst_w_valid_o)) r.stable = 1'b0;
      mst_ar_ready_i = mst_ar_valid_o && arw >= o.ar_d;
      if (mst_ar_valid_o) begin
        if (!seen_a) begin seen_a = 1; r.axaddr = mst_ar_addr_o; r.axsize = mst_ar_size_o; end
        else if (mst_ar_addr_o !== r.axaddr || mst_ar_size_o !== r.axsize) r.stable = 1'b0;
        if (mst_ar_ready_i) r.nar++;
        arw++;
      end
      mst_aw_ready_i = mst_aw_valid_o && aww >= o.aw_d;
      if (mst_aw_valid_o) begin
        if (!seen_a) begin seen_a = 1; r.axaddr = mst_aw_addr_o; r.axsize = mst_aw_size_o; end
        else if (mst_aw_addr_o !== r.axaddr || mst_aw_size_o !== r.axsize) r.stable = 1'b0;
        if (mst_aw_ready_i) r.naw++;
        aww++;
      end
      mst_w_ready_i = mst_w_valid_o && ww >= o.w_d;
      if (mst_w_valid_o) begin
        if (!seen_w) begin seen_w = 1; r.wdat = mst_w_data_o; r.strb = mst_w_strb_o; end
        else if (mst_w_data_o !== r.wdat || mst_w_strb_o !== r.strb) r.stable = 1'b0;
        if (mst_w_last_o !== 1'b1) r.stable = 1'b0;
        if (mst_w_ready_i) r.nw++;
        ww++;
      end
      pa = mst_ar_valid_o && !mst_ar_ready_i;
      paw = mst_aw_valid_o && !mst_aw_ready_i;
      pw = mst_w_valid_o && !mst_w_ready_i;
      mst_r_valid_i = mst_r_ready_o && rw >= o.r_d;
      mst_r_data_i = mst_r_valid_i ? o.sdata : $urandom;
      mst_r_resp_i = mst_r_valid_i ? o.resp : 2'($urandom);
      if (mst_r_ready_o) begin if (mst_r_valid_i) r.nresp++; rw++; end
      mst_b_valid_i = mst_b_ready_o && bw >= o.b_d;
      mst_b_resp_i = mst_b_valid_i ? o.resp : 2'($urandom);
      if (mst_b_ready_o) begin if (mst_b_valid_i) r.nresp++; bw++; end
      if (m_valid_o) begin
        if (r.lat < 0) begin r.lat = c; r.rdata = rdata_o; r.err = err_o; end
        else if (rdata_o !== r.rdata || err_o !== r.err) r.stable = 1'b0;
        m_ready_i = mw >= o.m_d;
        mw++;
        if (m_ready_i) done = 1;
      end else m_ready_i = 1'b0;
    end
    chk("handshake_timeout", 32'(done), 32'd1);
    @(negedge clk_i);
    e_valid_i = 1'b0; m_ready_i = 1'b0; mst_ar_ready_i = 1'b0; mst_aw_ready_i = 1'b0;
    mst_w_ready_i = 1'b0; mst_r_valid_i = 1'b0; mst_b_valid_i = 1'b0;
    if (e_ready_o !== 1'b1) r.stable = 1'b0;
  endtask

  task automatic cmp(input string t, input res_t a, input res_t e);
    if (!(e.nar == 1 && e.err)) chk({t, ".rdata"}, a.rdata, e.rdata);
    chk({t, ".err"}, 32'(a.err), 32'(e.err));
    chk({t, ".lat"}, 32'(a.lat), 32'(e.lat));
    chk({t, ".nar"}, 32'(a.nar), 32'(e.nar));
    chk({t, ".naw"}, 32'(a.naw), 32'(e.naw));
    chk({t, ".nw"}, 32'(a.nw), 32'(e.nw));
    chk({t, ".nresp"}, 32'(a.nresp), 32'(e.nresp));
    chk({t, ".stable"}, 32'(a.stable), 32'd1);
    if (e.nar + e.naw > 0) begin
      chk({t, ".axaddr"}, a.axaddr, e.axaddr);
      chk({t, ".axsize"}, 32'(a.axsize), 32'(e.axsize));
    end
    if (e.naw > 0) begin
      chk({t, ".wdata"}, a.wdat, e.wdat);
      chk({t, ".strb"}, 32'(a.strb), 32'(e.strb));
    end
  endtask

  vec_t vt[12];
  res_t r;
  op_t o;
  string tag;
  int k;

  initial begin
    vt[0] = '{mk(32'h8000_0003, 0, 32'h8012_3456, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 32'hFFFF_FF80, 0, 3, 1, 0, 0, 0};
    vt[1] = '{mk(32'h8000_0002, 0, 32'hBEEF_1234, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 32'h0000_BEEF, 0, 3, 1, 0, 0, 0};
    vt[2] = '{mk(32'h8000_0002, 32'h0000_ABCD, 0, 1, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0), 0, 0, 6, 0, 1, 32'hABCD_0000, 4'b1100};
    vt[3] = '{mk(32'h8000_0000, 0, 32'h1234_5678, 0, 1, 0, 2, 0, 4, 0, 0, 0, 0, 2), 32'h1234_5678, 0, 7, 1, 0, 0, 0};
    vt[4] = '{mk(32'h8000_0004, 32'hDEAD_BEEF, 0, 1, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0), 0, 1, 3, 0, 1, 32'hDEAD_BEEF, 4'b1111};
    if (ALN) vt[5] = '{mk(32'h8000_0001, 0, 32'hAABB_CCDD, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0};
    else vt[5] = '{mk(32'h8000_0001, 0, 32'hAABB_CCDD, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0), 32'h00AA_BBCC, 0, 3, 1, 0, 0, 0};
    vt[6] = '{mk(32'h8000_0010, 32'hFFFF_FFFF, 32'h5555_5555, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0};
    vt[7] = '{mk(32'h8000_0001, 32'h9999_9999, 32'h1122_3344, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h0000_0033, 0, 3, 1, 0, 0, 0};
    vt[8] = '{mk(32'h8000_0000, 0, 32'h1234_8001, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 32'hFFFF_8001, 0, 3, 1, 0, 0, 0};
    vt[9] = '{mk(32'h8000_0001, 32'h0000_00A5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 3, 0, 1, 32'h0000_A500, 4'b0010};
    vt[10] = '{mk(32'h8000_0008, 0, 32'hCAFE_F00D, 0, 1, 0, 2, 3, 0, 0, 0, 2, 0, 1), 0, 1, 5, 1, 0, 0, 0};
    vt[11] = '{mk(32'h8000_000C, 32'h0102_0304, 0, 1, 0, 0, 2, 0, 0, 2, 0, 0, 1, 0), 0, 0, 6, 0, 1, 32'h0102_0304, 4'b1111};
    repeat (2) @(negedge clk_i);
    chk("rst_valids", 32'({mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, m_valid_o}), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_e_ready", 32'(e_ready_o), 32'd1);
    for (int i = 0; i < 12; i++) begin
      run(vt[i].o, r);
      tag = $sformatf("vec%0d", i);
      if (!(vt[i].er && vt[i].nar == 1)) chk({tag, ".rdata"}, r.rdata, vt[i].rd);
      chk({tag, ".err"}, 32'(r.err), 32'(vt[i].er));
      chk({tag, ".lat"}, 32'(r.lat), 32'(vt[i].lat));
      chk({tag, ".nar"}, 32'(r.nar), 32'(vt[i].nar));
      chk({tag, ".naw"}, 32'(r.naw), 32'(vt[i].naw));
      chk({tag, ".nw"}, 32'(r.nw), 32'(vt[i].naw));
      chk({tag, ".stable"}, 32'(r.stable), 32'd1);
      if (vt[i].nar + vt[i].naw > 0) chk({tag, ".axaddr"}, r.axaddr, vt[i].o.addr);
      if (vt[i].naw > 0) begin
        chk({tag, ".wdata"}, r.wdat, vt[i].wd);
        chk({tag, ".strb"}, 32'(r.strb), 32'(vt[i].st));
      end
    end
    @(negedge clk_i);
    e_valid_i = 1'b1; renMem_i = 1'b1; wenMem_i = 1'b0; addr_i = 32'h8000_0000; size_i = 2'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    e_valid_i = 1'b0;
    mst_ar_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    mst_ar_ready_i = 1'b0;
    chk("pre_rst_r_ready", 32'(mst_r_ready_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_valids", 32'({mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, m_valid_o}), 32'd0);
    chk("midrst_rdata_err", {rdata_o[30:0], err_o}, 32'd0);
    chk("midrst_e_ready", 32'(e_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    run(vt[0].o, r);
    cmp("post_rst", r, model(vt[0].o));
    for (int i = 0; i < 200; i++) begin
      o.addr = 32'h8000_0000 | ($urandom & 32'hFF);
      o.wdata = $urandom;
      o.sdata = $urandom;
      k = $urandom_range(0, 9);
      o.ren = k < 4 || k == 9;
      o.wen = (k >= 4 && k < 8) || k == 9;
      o.sgn = 1'($urandom);
      o.size = 2'($urandom_range(0, 2));
      o.resp = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
      o.ar_d = $urandom_range(0, 3); o.aw_d = $urandom_range(0, 3); o.w_d = $urandom_range(0, 3);
      o.r_d = $urandom_range(0, 3); o.b_d = $urandom_range(0, 3); o.m_d = $urandom_range(0, 3);
      run(o, r);
      cmp($sformatf("rnd%0d", i), r, model(o));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
